// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester (fetch/data) arbiter onto one fixed-latency memory port.
// Revision 1.0 - initial release
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] C_SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic          sel_d;
  logic          op_we;

  logic any_req;
  logic pick_f;

  assign any_req = f_req | d_req;
  // Fetch only overtakes a competing data request once it has been starved enough.
  assign pick_f  = f_req & (~d_req | (starve_cnt == C_SMAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      sel_d      <= 1'b0;
      op_we      <= 1'b0;
      f_gnt      <= 1'b0;
      f_valid    <= 1'b0;
      f_rdata    <= '0;
      d_gnt      <= 1'b0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      f_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      mem_en  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            sel_d  <= ~pick_f;
            if (pick_f) begin
              f_gnt      <= 1'b1;
              op_we      <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= f_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              d_gnt     <= 1'b1;
              op_we     <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (f_req && starve_cnt != C_SMAX)
                starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          mem_we   <= 1'b0;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_cnt == C_LAST) begin
            state <= RESP;
            if (sel_d) begin
              d_valid <= 1'b1;
              // A write response leaves the data read port untouched.
              if (!op_we)
                d_rdata <= mem_rdata;
            end else begin
              f_valid <= 1'b1;
              f_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, memory address width.
REQ-002 Parameter DATA_W, 32, memory data width.
REQ-003 Parameter MEM_LAT, 2, fixed memory read latency in cycles, legal range >=1.
REQ-004 Parameter STARVE_MAX, 3, consecutive data grants tolerated while fetch waits.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 f_req / f_addr  in  1 / ADDR_W  fetch read request, address.
REQ-008 f_gnt / f_valid / f_rdata  out  1 / 1 / DATA_W  fetch grant pulse, response pulse, read data.
REQ-009 d_req / d_we / d_addr / d_wdata  in  1 / 1 / ADDR_W / DATA_W  data request, write enable, address, write data.
REQ-010 d_gnt / d_valid / d_rdata  out  1 / 1 / DATA_W  data grant pulse, response pulse, read data.
REQ-011 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  single memory port command.
REQ-012 mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-015 Arbitration SHALL be evaluated only in IDLE and RESP; any sampled request moves the FSM to ISSUE, none -> IDLE.
REQ-016 Priority: d wins over f, except f wins when both request and starve_cnt == STARVE_MAX.
REQ-017 starve_cnt SHALL increment (saturating at STARVE_MAX) on each d grant while f_req is high, and clear on every f grant.
REQ-018 At the decision edge, winner's addr, we (0 for fetch), wdata SHALL be latched into mem_addr/mem_we/mem_wdata.
REQ-019 ISSUE (cycle T): mem_en=1 and winner's gnt=1 for exactly one cycle; mem_we=1 only for a data write.
REQ-020 WAIT SHALL last exactly MEM_LAT cycles (T+1..T+MEM_LAT); mem_rdata captured on the last WAIT cycle.
REQ-021 RESP (cycle T+MEM_LAT+1): winner's valid=1 for one cycle with captured rdata on its rdata port.
REQ-022 Data write: d_valid pulses at the same RESP timing as a read; d_rdata holds its previous value.
REQ-023 x_rdata SHALL hold its value until that requester's next read response.
REQ-024 Requester holds req and payload stable until it sees gnt and drops req in the following cycle; req dropped before the decision edge is simply not served.
REQ-025 Request-to-grant latency from IDLE: 1 cycle; back-to-back transaction period: MEM_LAT+2 cycles.
REQ-026 mem_en, f_gnt, d_gnt, f_valid, d_valid SHALL never be high outside ISSUE/RESP respectively; at most one gnt and one valid per cycle.

Reset
REQ-027 reset high SHALL immediately force state IDLE, starve_cnt 0, all outputs 0 including rdata ports and busy.
REQ-028 Reset during ISSUE/WAIT/RESP SHALL abandon the transaction with no valid pulse; returned mem_rdata is ignored.
REQ-029 After reset release, the first request sampled in IDLE SHALL be served normally.

Verification (MEM_LAT=2, STARVE_MAX=3)
REQ-030 Single fetch: f_req=1, f_addr=0x10 at cycle 0 -> f_gnt, mem_en, mem_addr=0x10 at cycle 1; mem_rdata=0xDEADBEEF at cycle 3 -> f_valid=1, f_rdata=0xDEADBEEF at cycle 4.
REQ-031 Data write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55 -> mem_we=1, mem_wdata=0x55 for one cycle at 1, d_valid at 4, f outputs unchanged.
REQ-032 Simultaneous f_req and d_req at cycle 0 -> d_gnt at 1, RESP at 4, f_gnt at 5, f_valid at 8.
REQ-033 Starvation: f_req and d_req held continuously (d re-requesting) -> d granted 3 consecutive times, then f_gnt, then d again.
REQ-034 Reset pulsed in cycle 2 of a fetch -> all outputs 0 asynchronously, no f_valid; new d_req after release granted 1 cycle later.
REQ-035 Back-to-back data reads at addresses 0x01, 0x02 -> mem_en at cycles 1 and 5, d_valid at 4 and 8, busy high 1..8.
